updown_counter: RTL and testbench

- Synchronous binary up/down counter with a single direction-control input.
- Counts up or down by one on every rising clock edge. Wraps modulo 2^WIDTH in both directions.
- Leaf utility block, used standalone or as a sequencing/index source in larger datapaths.
- Default configuration is the 3-bit counter.

---
 rtl/counter_pkg.sv | 18 +
 rtl/updown_counter.sv | 56 +++++
 tb/tb_updown_counter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants for the up/down counter: default width and
//                the encoding of the direction-select input.
//  Contents    : COUNTER_WIDTH - default counter width in bits
//                DIR_DOWN      - ctrl value that selects a decrement
//                DIR_UP        - ctrl value that selects an increment
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int   COUNTER_WIDTH = 3;
    localparam logic DIR_DOWN      = 1'b0;
    localparam logic DIR_UP        = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter
//  Description : Free-running binary up/down counter. On every rising clock
//                edge out of reset the count steps by one in the direction
//                selected by ctrl, wrapping modulo 2^WIDTH both ways.
//  Parameters  : WIDTH       - counter width in bits (>= 1)
//                RESET_VALUE - value held while reset is asserted, truncated
//                              to WIDTH bits
//  Ports       : clk   in  1      rising-edge clock
//                rst   in  1      asynchronous reset, active-low
//                ctrl  in  1      direction: 1 = up, 0 = down
//                count out WIDTH  current count, straight from the register
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNTER_WIDTH,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_reset_value = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Sum and difference are kept at WIDTH bits so the carry/borrow out is
    // simply dropped, which gives the modulo-2^WIDTH wrap in both directions.
    always_comb begin
        w_next = r_count;
        if (ctrl == DIR_UP) begin
            w_next = r_count + c_one;
        end else begin
            w_next = r_count - c_one;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= c_reset_value;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule : updown_counter
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter
//  Description : Directed self-checking bench for updown_counter. Drives the
//                default 3-bit instance through reset, wrap, direction-change
//                and full-cycle sequences, and a WIDTH=4 / RESET_VALUE=9
//                instance through its reset value and wrap points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

    logic       clk;
    logic       rst;
    logic       ctrl;
    logic [2:0] count;

    logic       rst4;
    logic       ctrl4;
    logic [3:0] count4;

    int total;
    int bad;

    updown_counter u_dut (
        .clk   (clk),
        .rst   (rst),
        .ctrl  (ctrl),
        .count (count)
    );

    updown_counter #(
        .WIDTH       (4),
        .RESET_VALUE (9)
    ) u_dut4 (
        .clk   (clk),
        .rst   (rst4),
        .ctrl  (ctrl4),
        .count (count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock step on the 3-bit instance, checked 1 time unit after the edge.
    task automatic step(input logic dir, input int exp, input string tag);
        ctrl = dir;
        @(posedge clk);
        #1;
        chk(tag, int'(count), exp);
    endtask

    task automatic step4(input logic dir, input int exp, input string tag);
        ctrl4 = dir;
        @(posedge clk);
        #1;
        chk(tag, int'(count4), exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        ctrl  = 1'b0;
        rst4  = 1'b0;
        ctrl4 = 1'b1;

        // Reset held across edges with ctrl wiggling: count stays at 0 / 9.
        for (int i = 0; i < 3; i++) begin
            ctrl = ~ctrl;
            @(posedge clk);
            #1;
            chk("rst_hold", int'(count), 0);
            chk("rst_hold_w4", int'(count4), 9);
        end

        // Release between edges: no change until the next edge.
        rst = 1'b1;
        #2;
        chk("rst_release", int'(count), 0);

        // Down from 0 wraps to 7.
        step(1'b0, 7, "down_wrap");
        step(1'b0, 6, "down");
        step(1'b0, 5, "down");
        step(1'b0, 4, "down");

        // Get to 5 then assert reset mid-cycle.
        step(1'b1, 5, "up_to5");
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", int'(count), 0);
        rst = 1'b1;

        // From 0 down to 6, then up through the 7 -> 0 wrap.
        step(1'b0, 7, "down_wrap2");
        step(1'b0, 6, "down_to6");
        step(1'b1, 7, "up");
        step(1'b1, 0, "up_wrap");
        step(1'b1, 1, "up");
        step(1'b1, 2, "up");

        // Direction flips take effect on the very next edge.
        step(1'b1, 3, "up_to3");
        step(1'b0, 2, "flip_down");
        step(1'b0, 1, "down");
        step(1'b0, 0, "down");
        step(1'b1, 1, "flip_up");
        step(1'b1, 2, "up");
        step(1'b1, 3, "up");
        step(1'b1, 4, "up");
        step(1'b1, 5, "up");

        // ctrl glitches between edges are ignored; only the edge value counts.
        ctrl = 1'b1;
        #2;
        ctrl = 1'b0;
        #2;
        step(1'b0, 4, "glitch");

        // Back to 0, then a full up cycle and a full down cycle.
        for (int v = 3; v >= 0; v--) step(1'b0, v, "to_zero");
        for (int i = 1; i <= 8; i++) step(1'b1, i % 8, "full_up");
        for (int i = 7; i >= 0; i--) step(1'b0, i, "full_down");

        // WIDTH=4 instance: still holding 9, then up 7 edges wraps on the 7th.
        chk("w4_reset", int'(count4), 9);
        rst4 = 1'b1;
        for (int i = 10; i <= 16; i++) step4(1'b1, i % 16, "w4_up");
        step4(1'b0, 15, "w4_down_wrap");
        step4(1'b0, 14, "w4_down");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_updown_counter
`default_nettype wire
